// File: rtl/data_bus_fifo_buffer.sv
// Data bus buffer between the CPU internal bus and the external pins: posted-write
// FIFO drained by an ack handshake, validated input latch, SYNC status priority.
module data_bus_fifo_buffer #(
  parameter int XLEN  = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  inout  wire  [XLEN-1:0] bus,
  input  logic            sync,
  input  logic [XLEN-1:0] status,
  input  logic            wr_push,
  output logic            wr_full,
  output logic [CW-1:0]   wr_count,
  input  logic            flush,
  input  logic            in_latch,
  input  logic            in_enable,
  output logic            in_valid,
  inout  wire  [XLEN-1:0] ext,
  output logic            ext_out_valid,
  input  logic            ext_out_ack,
  output logic            overflow,
  output logic            bus_err
);

  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_rdPtr;
  logic [AW-1:0]   r_wrPtr;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_inReg;
  logic            r_inValid;
  logic            r_overflow;
  logic            r_busErr;

  logic            w_empty;
  logic            w_full;
  logic            w_extValid;
  logic            w_pop;
  logic            w_doPush;
  logic            w_latchOk;
  logic            w_extEn;
  logic [XLEN-1:0] w_extData;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_extValid = !w_empty && !sync;
  assign w_pop      = ext_out_ack && w_extValid;
  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign w_doPush   = wr_push && (!w_full || w_pop);
  assign w_latchOk  = in_latch && !sync && !w_extValid;

  assign w_extEn   = sync || !w_empty;
  assign w_extData = sync ? status : r_mem[r_rdPtr];

  assign ext = w_extEn   ? w_extData : {XLEN{1'bz}};
  assign bus = in_enable ? r_inReg   : {XLEN{1'bz}};

  assign wr_full       = w_full;
  assign wr_count      = r_count;
  assign ext_out_valid = w_extValid;
  assign in_valid      = r_inValid;
  assign overflow      = r_overflow;
  assign bus_err       = r_busErr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= bus;
        r_wrPtr        <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_doPush, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (wr_push && w_full && !w_pop && !flush) begin
      r_overflow <= 1'b1;
    end
  end

  // A fresh capture wins over the consume so new data is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inReg   <= '0;
      r_inValid <= 1'b0;
      r_busErr  <= 1'b0;
    end else begin
      if (w_latchOk) begin
        r_inReg   <= ext;
        r_inValid <= 1'b1;
      end else if (in_enable) begin
        r_inValid <= 1'b0;
      end
      if (in_latch && !w_latchOk) begin
        r_busErr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_bus_fifo_buffer.sv
// Directed bench for data_bus_fifo_buffer: FIFO order, wrap, SYNC priority,
// input latch, loopback, flush, overflow and asynchronous reset.
module tb_data_bus_fifo_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sync, wrPush, flush, inLatch, inEnable, ackIn;
  logic [7:0] status;
  logic       busEn, extEn;
  logic [7:0] busDrv, extDrv;
  wire  [7:0] bus, ext;
  logic       wrFull, inValid, extOutValid, overflow, busErr;
  logic [2:0] wrCount;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] expQ[$];

  assign bus = busEn ? busDrv : 8'bz;
  assign ext = extEn ? extDrv : 8'bz;

  always #5 clk = ~clk;

  data_bus_fifo_buffer #(.XLEN(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .sync(sync), .status(status),
    .wr_push(wrPush), .wr_full(wrFull), .wr_count(wrCount), .flush(flush),
    .in_latch(inLatch), .in_enable(inEnable), .in_valid(inValid), .ext(ext),
    .ext_out_valid(extOutValid), .ext_out_ack(ackIn), .overflow(overflow),
    .bus_err(busErr)
  );

  // One clock cycle with an optional bus push and ack; outputs settle before return.
  task automatic applyStimulus(input logic push, input logic drive, input logic [7:0] data,
                               input logic ack);
    wrPush = push;
    busEn  = drive;
    busDrv = data;
    ackIn  = ack;
    @(posedge clk);
    #1;
    wrPush = 1'b0;
    busEn  = 1'b0;
    ackIn  = 1'b0;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0; sync = 1'b0; status = 8'h00; wrPush = 1'b0; flush = 1'b0;
    inLatch = 1'b0; inEnable = 1'b0; ackIn = 1'b0;
    busEn = 1'b0; busDrv = 8'h00; extEn = 1'b0; extDrv = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;

    // Reset state; released pins must follow the external drivers.
    checkOutput("rst_count", 16'(wrCount), 16'd0);
    checkOutput("rst_full", 16'(wrFull), 16'd0);
    checkOutput("rst_valid", 16'(extOutValid), 16'd0);
    checkOutput("rst_in_valid", 16'(inValid), 16'd0);
    checkOutput("rst_overflow", 16'(overflow), 16'd0);
    checkOutput("rst_bus_err", 16'(busErr), 16'd0);
    extEn = 1'b1; extDrv = 8'h5A; busEn = 1'b1; busDrv = 8'hC3;
    #1;
    checkOutput("rst_ext_released", 16'(ext), 16'h005A);
    checkOutput("rst_bus_released", 16'(bus), 16'h00C3);
    extEn = 1'b0; busEn = 1'b0;

    // SYNC priority: status wins, head held and ack ignored.
    applyStimulus(1'b1, 1'b1, 8'hA5, 1'b0);
    checkOutput("sync_pre_head", 16'(ext), 16'h00A5);
    sync = 1'b1; status = 8'hA2;
    #1;
    checkOutput("sync_ext", 16'(ext), 16'h00A2);
    checkOutput("sync_valid", 16'(extOutValid), 16'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("sync_ack_ignored", 16'(wrCount), 16'd1);
    sync = 1'b0;
    #1;
    checkOutput("sync_drop_ext", 16'(ext), 16'h00A5);
    checkOutput("sync_drop_valid", 16'(extOutValid), 16'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("sync_pop_count", 16'(wrCount), 16'd0);

    // Fill, then push+pop while full, then wrap the pointers repeatedly.
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 1'b1, 8'(i), 1'b0);
    checkOutput("fill_full", 16'(wrFull), 16'd1);
    checkOutput("fill_count", 16'(wrCount), 16'd4);
    applyStimulus(1'b1, 1'b1, 8'h66, 1'b1);
    checkOutput("fullpp_count", 16'(wrCount), 16'd4);
    checkOutput("fullpp_overflow", 16'(overflow), 16'd0);
    expQ = '{8'h02, 8'h03, 8'h04, 8'h66};
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("wrap_head%0d", i), 16'(ext), 16'(expQ[0]));
      applyStimulus(1'b1, 1'b1, 8'(8'h70 + i), 1'b1);
      void'(expQ.pop_front());
      expQ.push_back(8'(8'h70 + i));
    end
    checkOutput("wrap_count", 16'(wrCount), 16'd4);
    checkOutput("wrap_overflow", 16'(overflow), 16'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("wrap_drain%0d", i), 16'(ext), 16'(8'h76 + i));
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    end
    checkOutput("wrap_empty_valid", 16'(extOutValid), 16'd0);

    // Input latch, consume, contention error, loopback.
    extEn = 1'b1; extDrv = 8'h3C; inLatch = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    inLatch = 1'b0; extEn = 1'b0;
    checkOutput("latch_valid", 16'(inValid), 16'd1);
    checkOutput("latch_no_err", 16'(busErr), 16'd0);
    inEnable = 1'b1;
    #1;
    checkOutput("latch_bus", 16'(bus), 16'h003C);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    inEnable = 1'b0;
    #1;
    checkOutput("latch_consumed", 16'(inValid), 16'd0);
    applyStimulus(1'b1, 1'b1, 8'h99, 1'b0);
    inLatch = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    inLatch = 1'b0;
    checkOutput("contend_bus_err", 16'(busErr), 16'd1);
    checkOutput("contend_in_valid", 16'(inValid), 16'd0);
    inEnable = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    inEnable = 1'b0;
    checkOutput("loop_count", 16'(wrCount), 16'd2);
    checkOutput("loop_head", 16'(ext), 16'h0099);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("loop_pushed_reg", 16'(ext), 16'h003C);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    // Flush beats a simultaneous push; flags untouched.
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 1'b1, 8'(i), 1'b0);
    checkOutput("preflush_count", 16'(wrCount), 16'd3);
    flush = 1'b1;
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b0);
    flush = 1'b0;
    checkOutput("flush_count", 16'(wrCount), 16'd0);
    checkOutput("flush_overflow", 16'(overflow), 16'd0);
    checkOutput("flush_valid", 16'(extOutValid), 16'd0);
    checkOutput("flush_bus_err_kept", 16'(busErr), 16'd1);
    extEn = 1'b1; extDrv = 8'h5A;
    #1;
    checkOutput("flush_ext_released", 16'(ext), 16'h005A);
    extEn = 1'b0;

    // Overflow on a fifth push, then ordered drain.
    applyStimulus(1'b1, 1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h22, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h33, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h44, 1'b0);
    checkOutput("ovf_not_yet", 16'(overflow), 16'd0);
    applyStimulus(1'b1, 1'b1, 8'h55, 1'b0);
    checkOutput("ovf_flag", 16'(overflow), 16'd1);
    checkOutput("ovf_count", 16'(wrCount), 16'd4);
    checkOutput("ovf_full", 16'(wrFull), 16'd1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("ovf_drain%0d", i), 16'(ext), 16'(8'h11 * i));
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    end
    checkOutput("ovf_drained_valid", 16'(extOutValid), 16'd0);

    // Asynchronous reset in the middle of a pop, no clock edge needed.
    extEn = 1'b1; extDrv = 8'h5E; inLatch = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    inLatch = 1'b0; extEn = 1'b0;
    applyStimulus(1'b1, 1'b1, 8'hB1, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hB2, 1'b0);
    checkOutput("prereset_in_valid", 16'(inValid), 16'd1);
    checkOutput("prereset_count", 16'(wrCount), 16'd2);
    ackIn = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("arst_count", 16'(wrCount), 16'd0);
    checkOutput("arst_valid", 16'(extOutValid), 16'd0);
    checkOutput("arst_in_valid", 16'(inValid), 16'd0);
    checkOutput("arst_overflow", 16'(overflow), 16'd0);
    checkOutput("arst_bus_err", 16'(busErr), 16'd0);
    ackIn = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    inEnable = 1'b1;
    #1;
    checkOutput("arst_in_reg_zero", 16'(bus), 16'h0000);
    inEnable = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
